// File: rtl/cve2_rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback sequencer.
// Entries carry WB_DATA_W data bits; the sequencer's DataWidth must match.
package cve2_rf_wb_pkg;

  localparam int RF_ADDR_W_MAX = 5;
  localparam int WB_DATA_W     = 32;

  typedef struct packed {
    logic                     valid;
    logic [RF_ADDR_W_MAX-1:0] waddr;
    logic [WB_DATA_W-1:0]     wdata;
  } wb_entry_t;

  // RV32E only decodes 16 registers, so the top address bit is ignored there
  function automatic logic addr_match(input logic [RF_ADDR_W_MAX-1:0] a,
                                      input logic [RF_ADDR_W_MAX-1:0] b,
                                      input logic                     rv32e);
    if (rv32e) return a[3:0] == b[3:0];
    return a == b;
  endfunction

endpackage

// File: rtl/cve2_rf_wb_fifo.sv
// Pending LSU writeback queue: push/pop, per-entry kill by address, and an
// oldest-to-newest view of all entries for read forwarding.
module cve2_rf_wb_fifo
  import cve2_rf_wb_pkg::*;
#(
  parameter int FifoDepth = 2,
  parameter bit RV32E     = 1'b0
) (
  input  logic                             clk_int,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  wb_entry_t                        push_entry_i,
  input  logic                             pop_i,
  input  logic                             kill_i,
  input  logic [RF_ADDR_W_MAX-1:0]         kill_addr_i,
  output logic [$clog2(FifoDepth+1)-1:0]   count_o,
  output wb_entry_t                        head_o,
  output wb_entry_t                        ordered_o [FifoDepth]
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth + 1);

  wb_entry_t       mem_q [FifoDepth];
  wb_entry_t       push_entry;
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // A same-cycle ALU write to the pushed address is younger, so the entry lands dead
  always_comb begin
    push_entry       = push_entry_i;
    push_entry.valid = push_entry_i.valid &
                       ~(kill_i & addr_match(push_entry_i.waddr, kill_addr_i, RV32E));
    rptr_d  = pop_i  ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = push_i ? ptr_inc(wptr_q) : wptr_q;
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < FifoDepth; i++) begin
        if (kill_i && mem_q[i].valid && addr_match(mem_q[i].waddr, kill_addr_i, RV32E)) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      if (push_i) mem_q[wptr_q] <= push_entry;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Slot k of the view is the k-th oldest occupied entry; free slots read as invalid
  always_comb begin
    int pos;
    pos = 0;
    for (int k = 0; k < FifoDepth; k++) begin
      pos = int'(rptr_q) + k;
      if (pos >= FifoDepth) pos = pos - FifoDepth;
      ordered_o[k]       = mem_q[pos[PtrW-1:0]];
      ordered_o[k].valid = mem_q[pos[PtrW-1:0]].valid && (k < int'(count_q));
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/cve2_rf_wb_sequencer.sv
// Register-file write-port sequencer for ALU and LSU writeback with read forwarding.
// CVE2_RF_WB_BYPASS_EN selects forwarding; otherwise reads pass through and hazard_o stalls decode.
module cve2_rf_wb_sequencer
  import cve2_rf_wb_pkg::*;
#(
  parameter int DataWidth = WB_DATA_W,
  parameter int RV32E     = 0,
  parameter int FifoDepth = 2
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 alu_we_i,
  input  logic [4:0]           alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 hazard_o,
  output logic                 idle_o
);

  localparam int CntW     = $clog2(FifoDepth + 1);
  localparam bit IsRv32e  = (RV32E != 0);

  logic [CntW-1:0]      count;
  wb_entry_t            head, push_entry;
  wb_entry_t            ordered [FifoDepth];
  logic                 push, pop, kill, lsu_fire, alu_x0, lsu_x0;
  logic                 inflight_we_q;
  logic [4:0]           inflight_waddr_q;
  logic [DataWidth-1:0] inflight_wdata_q;
  logic [4:0]           raddr     [2];
  logic [DataWidth-1:0] rf_rdata  [2];
  logic [DataWidth-1:0] fwd_rdata [2];
  logic [1:0]           port_hazard;

  // Ready comes from the registered count only, so a draining full FIFO stays not-ready
  assign lsu_ready_o = count < CntW'(FifoDepth);
  assign lsu_fire    = lsu_valid_i & lsu_ready_o;
  assign alu_x0      = addr_match(alu_waddr_i, 5'd0, IsRv32e);
  assign lsu_x0      = addr_match(lsu_waddr_i, 5'd0, IsRv32e);
  assign kill        = alu_we_i & ~alu_x0;
  assign push        = lsu_fire & ~lsu_x0 & (alu_we_i | (count != '0));
  assign pop         = ~alu_we_i & (count != '0);
  assign push_entry  = '{valid: 1'b1, waddr: lsu_waddr_i, wdata: lsu_wdata_i};

  cve2_rf_wb_fifo #(
    .FifoDepth (FifoDepth),
    .RV32E     (IsRv32e)
  ) u_fifo (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (kill),
    .kill_addr_i  (alu_waddr_i),
    .count_o      (count),
    .head_o       (head),
    .ordered_o    (ordered)
  );

  // ALU never stalls, queued LSU results go before new ones to keep ordering
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (alu_we_i) begin
      rf_we_o    = ~alu_x0;
      rf_waddr_o = alu_waddr_i;
      rf_wdata_o = alu_wdata_i;
    end else if (count != '0) begin
      rf_we_o    = head.valid;
      rf_waddr_o = head.waddr;
      rf_wdata_o = head.wdata;
    end else if (lsu_fire) begin
      rf_we_o    = ~lsu_x0;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_we_q    <= 1'b0;
      inflight_waddr_q <= '0;
      inflight_wdata_q <= '0;
    end else begin
      inflight_we_q    <= rf_we_o;
      inflight_waddr_q <= rf_waddr_o;
      inflight_wdata_q <= rf_wdata_o;
    end
  end

  assign raddr[0]    = raddr_a_i;
  assign raddr[1]    = raddr_b_i;
  assign rf_rdata[0] = rf_rdata_a_i;
  assign rf_rdata[1] = rf_rdata_b_i;

  // Later (newer) FIFO matches override the in-flight value, which overrides the RF
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_rdata[p]   = rf_rdata[p];
      port_hazard[p] = 1'b0;
      if (!addr_match(raddr[p], 5'd0, IsRv32e)) begin
        if (inflight_we_q && addr_match(inflight_waddr_q, raddr[p], IsRv32e)) begin
          fwd_rdata[p]   = inflight_wdata_q;
          port_hazard[p] = 1'b1;
        end
        for (int k = 0; k < FifoDepth; k++) begin
          if (ordered[k].valid && addr_match(ordered[k].waddr, raddr[p], IsRv32e)) begin
            fwd_rdata[p]   = ordered[k].wdata;
            port_hazard[p] = 1'b1;
          end
        end
      end
    end
  end

`ifdef CVE2_RF_WB_BYPASS_EN
  logic unused_hazard;
  assign unused_hazard = ^port_hazard;
  assign rdata_a_o     = fwd_rdata[0];
  assign rdata_b_o     = fwd_rdata[1];
  assign hazard_o      = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rdata[0], fwd_rdata[1]};
  assign rdata_a_o  = rf_rdata_a_i;
  assign rdata_b_o  = rf_rdata_b_i;
  assign hazard_o   = |port_hazard;
`endif

  assign idle_o = (count == '0) & ~inflight_we_q;

endmodule

// File: tb/tb_cve2_rf_wb_sequencer.sv
// Self-checking bench for cve2_rf_wb_sequencer: directed scenarios plus random traffic
// against a queue-based writeback model; honours CVE2_RF_WB_BYPASS_EN like the design.
module tb_cve2_rf_wb_sequencer;

   localparam int DEPTH = 2;

   logic        clk_int = 1'b0;
   logic        rst_ni  = 1'b0;
   logic        alu_we_i, lsu_valid_i, lsu_ready_o, rf_we_o, hazard_o, idle_o;
   logic [4:0]  alu_waddr_i, lsu_waddr_i, rf_waddr_o, raddr_a_i, raddr_b_i;
   logic [31:0] alu_wdata_i, lsu_wdata_i, rf_wdata_o;
   logic [31:0] rf_rdata_a_i, rf_rdata_b_i, rdata_a_o, rdata_b_o;

   always #5 clk_int = ~clk_int;

   cve2_rf_wb_sequencer #(.DataWidth(32), .RV32E(0), .FifoDepth(DEPTH)) dut (
      .clk_int(clk_int), .rst_ni(rst_ni),
      .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
      .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
      .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
      .hazard_o(hazard_o), .idle_o(idle_o)
   );

   // Register file stand-in: a write issued in cycle N becomes readable in cycle N+2
   logic [31:0] rfArr [32];
   logic        stWe;
   logic [4:0]  stAddr;
   logic [31:0] stData;

   always @(posedge clk_int) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) rfArr[i] <= (i == 0) ? 32'h0 : (32'h1000_0000 | 32'(i));
         stWe   <= 1'b0;
         stAddr <= '0;
         stData <= '0;
      end else begin
         if (stWe) rfArr[stAddr] <= stData;
         stWe   <= rf_we_o;
         stAddr <= rf_waddr_o;
         stData <= rf_wdata_o;
      end
   end

   assign rf_rdata_a_i = rfArr[raddr_a_i];
   assign rf_rdata_b_i = rfArr[raddr_b_i];

   // Behavioural model: pending LSU writes in program order plus the architectural register view
   typedef struct {
      logic        valid;
      logic [4:0]  addr;
      logic [31:0] data;
   } pend_t;

   pend_t       pq[$];
   logic [31:0] arch [32];
   logic        lastWe;
   logic [4:0]  lastAddr;
   int          expSrc;
   logic        expWe, expFire;
   logic [4:0]  expAddr;
   logic [31:0] expData;
   int          checks   = 0;
   int          failures = 0;

   task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      pq.delete();
      lastWe   = 1'b0;
      lastAddr = '0;
      expSrc   = 0;
      expWe    = 1'b0;
      expFire  = 1'b0;
      for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'h0 : (32'h1000_0000 | 32'(i));
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] r);
      if (r == 5'd0) return rfArr[0];
      for (int k = pq.size() - 1; k >= 0; k--)
         if (pq[k].valid && pq[k].addr == r) return pq[k].data;
      return arch[r];
   endfunction

   function automatic logic expHaz(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (lastWe && lastAddr == r) return 1'b1;
      foreach (pq[k]) if (pq[k].valid && pq[k].addr == r) return 1'b1;
      return 1'b0;
   endfunction

   // Compare every DUT output against what the model says this cycle must produce
   task automatic checkOutput();
      logic expReady;
      expReady = (pq.size() < DEPTH);
      expFire  = lsu_valid_i && expReady;
      if (alu_we_i) begin
         expSrc = 1; expWe = (alu_waddr_i != 0); expAddr = alu_waddr_i; expData = alu_wdata_i;
      end else if (pq.size() > 0) begin
         expSrc = 2; expWe = pq[0].valid; expAddr = pq[0].addr; expData = pq[0].data;
      end else if (expFire) begin
         expSrc = 3; expWe = (lsu_waddr_i != 0); expAddr = lsu_waddr_i; expData = lsu_wdata_i;
      end else begin
         expSrc = 0; expWe = 1'b0; expAddr = '0; expData = '0;
      end
      compareValue("lsu_ready", lsu_ready_o, expReady);
      compareValue("rf_we", rf_we_o, expWe);
      if (expWe) begin
         compareValue("rf_waddr", rf_waddr_o, expAddr);
         compareValue("rf_wdata", rf_wdata_o, expData);
      end
`ifdef CVE2_RF_WB_BYPASS_EN
      compareValue("rdata_a", rdata_a_o, expRead(raddr_a_i));
      compareValue("rdata_b", rdata_b_o, expRead(raddr_b_i));
      compareValue("hazard", hazard_o, 1'b0);
`else
      compareValue("rdata_a", rdata_a_o, rfArr[raddr_a_i]);
      compareValue("rdata_b", rdata_b_o, rfArr[raddr_b_i]);
      compareValue("hazard", hazard_o, expHaz(raddr_a_i) | expHaz(raddr_b_i));
`endif
      compareValue("idle", idle_o, (pq.size() == 0) && !lastWe);
   endtask

   task automatic advanceModel();
      if (alu_we_i && alu_waddr_i != 0)
         foreach (pq[k]) if (pq[k].addr == alu_waddr_i) pq[k].valid = 1'b0;
      if (expSrc == 2) void'(pq.pop_front());
      if (expFire && lsu_waddr_i != 0 && expSrc != 3)
         pq.push_back(pend_t'{valid: !(alu_we_i && alu_waddr_i != 0 && alu_waddr_i == lsu_waddr_i),
                              addr: lsu_waddr_i, data: lsu_wdata_i});
      if (expWe) arch[expAddr] = expData;
      lastWe   = expWe;
      lastAddr = expAddr;
   endtask

   task automatic applyStimulus(input logic aWe, input logic [4:0] aAddr, input logic [31:0] aData,
                                input logic lV, input logic [4:0] lAddr, input logic [31:0] lData,
                                input logic [4:0] rA, input logic [4:0] rB);
      @(negedge clk_int);
      alu_we_i = aWe; alu_waddr_i = aAddr; alu_wdata_i = aData;
      lsu_valid_i = lV; lsu_waddr_i = lAddr; lsu_wdata_i = lData;
      raddr_a_i = rA; raddr_b_i = rB;
      #2;
      checkOutput();
   endtask

   task automatic endCycle();
      @(posedge clk_int);
      advanceModel();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
         endCycle();
      end
   endtask

   task automatic doReset();
      @(negedge clk_int);
      rst_ni = 1'b0;
      alu_we_i = 0; alu_waddr_i = 0; alu_wdata_i = 0;
      lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
      raddr_a_i = 0; raddr_b_i = 0;
      resetModel();
      repeat (2) @(posedge clk_int);
      @(negedge clk_int);
      rst_ni = 1'b1;
      #2;
   endtask

   initial begin
      logic        lV, lastFired;
      logic [4:0]  lA;
      logic [31:0] lD;

      doReset();
      compareValue("reset idle", idle_o, 1'b1);
      compareValue("reset ready", lsu_ready_o, 1'b1);
      compareValue("reset hazard", hazard_o, 1'b0);
      compareValue("reset rf_we", rf_we_o, 1'b0);
      endCycle();

      // LSU alone goes straight to the port, then is visible via the in-flight register
      applyStimulus(0, 0, 0, 1, 5'd5, 32'hA5A5_0001, 0, 0);
      compareValue("lsu-only we", rf_we_o, 1'b1);
      compareValue("lsu-only waddr", rf_waddr_o, 5'd5);
      compareValue("lsu-only wdata", rf_wdata_o, 32'hA5A5_0001);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 0);
`ifdef CVE2_RF_WB_BYPASS_EN
      compareValue("lsu-only fwd", rdata_a_o, 32'hA5A5_0001);
`else
      compareValue("lsu-only hazard", hazard_o, 1'b1);
      compareValue("lsu-only raw", rdata_a_o, 32'h1000_0005);
`endif
      endCycle();
      idleCycles(2);

      // ALU and LSU collide: ALU first, queued load next cycle
      applyStimulus(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 0, 0);
      compareValue("conflict waddr", rf_waddr_o, 5'd3);
      compareValue("conflict wdata", rf_wdata_o, 32'h11);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 0);
      compareValue("conflict drain waddr", rf_waddr_o, 5'd7);
      compareValue("conflict drain wdata", rf_wdata_o, 32'h22);
`ifdef CVE2_RF_WB_BYPASS_EN
      compareValue("conflict fwd", rdata_a_o, 32'h22);
`else
      compareValue("conflict hazard", hazard_o, 1'b1);
`endif
      endCycle();
      idleCycles(2);

      // A younger ALU write kills the queued load to the same register
      applyStimulus(1, 5'd1, 32'h1, 1, 5'd9, 32'hBB, 0, 0);
      endCycle();
      applyStimulus(1, 5'd9, 32'hCC, 0, 0, 0, 5'd9, 0);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd9, 0);
      compareValue("kill pop we", rf_we_o, 1'b0);
`ifdef CVE2_RF_WB_BYPASS_EN
      compareValue("kill fwd", rdata_a_o, 32'hCC);
`else
      compareValue("kill hazard", hazard_o, 1'b1);
`endif
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd9, 0);
      compareValue("kill rf x9", rfArr[9], 32'hCC);
      compareValue("kill read", rdata_a_o, 32'hCC);
      endCycle();
      idleCycles(2);

      // Four back-to-back ALU writes fill the two-entry FIFO
      applyStimulus(1, 5'd10, 32'hA0, 1, 5'd20, 32'hB0, 5'd20, 5'd21);
      compareValue("full ready c1", lsu_ready_o, 1'b1);
      endCycle();
      applyStimulus(1, 5'd11, 32'hA1, 1, 5'd21, 32'hB1, 5'd20, 5'd21);
      compareValue("full ready c2", lsu_ready_o, 1'b1);
      endCycle();
      applyStimulus(1, 5'd12, 32'hA2, 1, 5'd22, 32'hB2, 5'd20, 5'd21);
      compareValue("full ready c3", lsu_ready_o, 1'b0);
      endCycle();
      applyStimulus(1, 5'd13, 32'hA3, 1, 5'd22, 32'hB2, 5'd20, 5'd21);
      compareValue("full ready c4", lsu_ready_o, 1'b0);
      endCycle();
      applyStimulus(0, 0, 0, 1, 5'd22, 32'hB2, 5'd20, 5'd22);
      compareValue("full ready c5", lsu_ready_o, 1'b0);
      compareValue("full drain0 waddr", rf_waddr_o, 5'd20);
      compareValue("full drain0 wdata", rf_wdata_o, 32'hB0);
      endCycle();
      applyStimulus(0, 0, 0, 1, 5'd22, 32'hB2, 5'd21, 5'd22);
      compareValue("full ready c6", lsu_ready_o, 1'b1);
      compareValue("full drain1 waddr", rf_waddr_o, 5'd21);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd22, 5'd21);
      compareValue("full drain2 waddr", rf_waddr_o, 5'd22);
      compareValue("full drain2 wdata", rf_wdata_o, 32'hB2);
      endCycle();
      idleCycles(3);

      // x0 loads are accepted but never written
      applyStimulus(0, 0, 0, 1, 5'd0, 32'hFF, 0, 0);
      compareValue("x0 we", rf_we_o, 1'b0);
      compareValue("x0 ready", lsu_ready_o, 1'b1);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      compareValue("x0 idle", idle_o, 1'b1);
      compareValue("x0 ready after", lsu_ready_o, 1'b1);
      endCycle();

      // Reset with two queued loads drops them
      applyStimulus(1, 5'd2, 32'h2, 1, 5'd12, 32'hC, 0, 0);
      endCycle();
      applyStimulus(1, 5'd3, 32'h3, 1, 5'd13, 32'hD, 0, 0);
      endCycle();
      doReset();
      compareValue("post-reset rf_we", rf_we_o, 1'b0);
      compareValue("post-reset idle", idle_o, 1'b1);
      compareValue("post-reset ready", lsu_ready_o, 1'b1);
      endCycle();
      idleCycles(2);

      // Random traffic; the LSU holds its request until accepted
      lV = 1'b0; lA = '0; lD = '0; lastFired = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (!lV || lastFired) begin
            lV = ($urandom_range(0, 1) == 1);
            lA = 5'($urandom_range(0, 7));
            lD = $urandom;
         end
         applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                       lV, lA, lD, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         endCycle();
         lastFired = expFire;
         if (cyc == 2000) begin
            doReset();
            compareValue("mid reset idle", idle_o, 1'b1);
            endCycle();
            lV = 1'b0;
         end
      end
      idleCycles(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
